// File: rtl/multibyte_add_seq_pkg.sv
// Shared definitions for the byte-serial wide adder: byte width, FSM state
// encodings and the counter-width helper.
package multibyte_add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte counter needs at least one bit even for a single-byte operand.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/multibyte_add_seq_if.sv
// Start/done request bus between a controller and the wide-add sequencer.
interface multibyte_add_seq_if
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
);

  localparam int W = NBYTES * BYTE_W;

  logic         iStart;
  logic [W-1:0] iData_a;
  logic [W-1:0] iData_b;
  logic         iC;
  logic         oReady;
  logic         oBusy;
  logic [W-1:0] oData;
  logic         oData_C;
  logic         oDone;

  modport master (
    output iStart, iData_a, iData_b, iC,
    input  oReady, oBusy, oData, oData_C, oDone
  );

  modport slave (
    input  iStart, iData_a, iData_b, iC,
    output oReady, oBusy, oData, oData_C, oDone
  );

endinterface

// File: rtl/multibyte_add_seq_adder.sv
// The team's 8-bit combinational adder with carry in and carry out.
module multibyte_add_seq_adder
  import multibyte_add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] iData_a,
  input  logic [BYTE_W-1:0] iData_b,
  input  logic              iC,
  output logic [BYTE_W-1:0] oData,
  output logic              oData_C
);

  logic [BYTE_W:0] sum;

  // Nine-bit sum: the top bit is the carry out.
  always_comb begin
    sum     = {1'b0, iData_a} + {1'b0, iData_b} + {{BYTE_W{1'b0}}, iC};
    oData   = sum[BYTE_W-1:0];
    oData_C = sum[BYTE_W];
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder: feeds one byte pair per clock (LSB first) through a
// single 8-bit adder, chaining the carry through a register, and publishes
// the complete sum and carry-out with a one-cycle done pulse.
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
)(
  input  logic                iClk,
  input  logic                iRst,
  multibyte_add_seq_if.slave  bus
);

  localparam int W     = NBYTES * BYTE_W;
  localparam int CNT_W = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  state_t             state_q;
  logic [W-1:0]       a_sh_q;
  logic [W-1:0]       b_sh_q;
  logic [W-1:0]       acc_q;
  logic [W-1:0]       acc_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       data_q;
  logic               data_c_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;

  logic [BYTE_W-1:0]  add_sum;
  logic               add_co;

  multibyte_add_seq_adder u_adder (
    .iData_a (a_sh_q[BYTE_W-1:0]),
    .iData_b (b_sh_q[BYTE_W-1:0]),
    .iC      (carry_q),
    .oData   (add_sum),
    .oData_C (add_co)
  );

  // Accumulator shifts right a byte per step; the new byte enters at the top
  // so that after NBYTES steps the LSB byte has reached bit 0.
  always_comb begin
    acc_d = (acc_q >> BYTE_W) | (W'(add_sum) << (W - BYTE_W));
  end

  // Sequencer FSM with all datapath and output registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      data_c_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iStart) begin
            a_sh_q  <= bus.iData_a;
            b_sh_q  <= bus.iData_b;
            carry_q <= bus.iC;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          carry_q <= add_co;
          a_sh_q  <= a_sh_q >> BYTE_W;
          b_sh_q  <= b_sh_q >> BYTE_W;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            // Publish only the finished result, never a partial one.
            data_q   <= acc_d;
            data_c_q <= add_co;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oReady  = ready_q;
  assign bus.oBusy   = busy_q;
  assign bus.oData   = data_q;
  assign bus.oData_C = data_c_q;
  assign bus.oDone   = done_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed bench for the byte-serial wide adder with NBYTES=4.
module tb_multibyte_add_seq;
  import multibyte_add_seq_pkg::*;

  localparam int NBYTES = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multibyte_add_seq_if #(.NBYTES(NBYTES)) bus ();

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; operands are scrambled right after accept.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic [31:0] exp_d, input logic exp_c);
    int n;
    check_eq({tag, "_ready"}, 64'(bus.oReady), 64'd1);
    bus.iStart  = 1'b1;
    bus.iData_a = a;
    bus.iData_b = b;
    bus.iC      = c;
    tick();
    bus.iStart  = 1'b0;
    bus.iData_a = ~a;
    bus.iData_b = ~b;
    bus.iC      = ~c;
    check_eq({tag, "_busy"}, 64'({bus.oBusy, bus.oReady}), 64'b10);
    n = 1;
    while (!bus.oDone && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'd5);
    check_eq({tag, "_data"}, 64'(bus.oData), 64'(exp_d));
    check_eq({tag, "_carry"}, 64'(bus.oData_C), 64'(exp_c));
    tick();
    check_eq({tag, "_idle"}, 64'({bus.oDone, bus.oBusy, bus.oReady}), 64'b001);
    check_eq({tag, "_hold"}, 64'(bus.oData), 64'(exp_d));
  endtask

  initial begin
    int acc1, acc2, dones, late_dones;
    logic prev_ready;
    logic [31:0] last;

    rst         = 1'b1;
    bus.iStart  = 1'b0;
    bus.iData_a = '0;
    bus.iData_b = '0;
    bus.iC      = 1'b0;
    tick();
    tick();
    check_eq("rst_ready", 64'(bus.oReady), 64'd1);
    check_eq("rst_busy", 64'(bus.oBusy), 64'd0);
    check_eq("rst_done", 64'(bus.oDone), 64'd0);
    check_eq("rst_data", 64'(bus.oData), 64'd0);
    check_eq("rst_carry", 64'(bus.oData_C), 64'd0);
    rst = 1'b0;
    tick();

    run_op("zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    run_op("7f",     32'h7F7F_7F7F, 32'h7F7F_7F7F, 1'b1, 32'hFEFE_FEFF, 1'b0);
    run_op("aa55",   32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1);
    run_op("mixed",  32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0);

    // iStart held high: back-to-back accepts, operand changes mid-run ignored.
    acc1  = -1;
    acc2  = -1;
    dones = 0;
    last  = 32'h9999_9999;
    prev_ready  = 1'b1;
    bus.iStart  = 1'b1;
    bus.iData_a = 32'h0000_0001;
    bus.iData_b = 32'h0000_0002;
    bus.iC      = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      tick();
      if (prev_ready && !bus.oReady) begin
        if (acc1 < 0) begin
          acc1 = cyc;
          bus.iData_a = 32'h0000_0010;
          bus.iData_b = 32'h0000_0020;
        end else if (acc2 < 0) begin
          acc2 = cyc;
          bus.iStart  = 1'b0;
          bus.iData_a = 32'h0000_0055;
          bus.iData_b = 32'h0000_0066;
        end
      end
      if (bus.oDone) begin
        dones++;
        if (dones == 1) begin
          check_eq("b2b_op1", 64'(bus.oData), 64'h3);
          last = 32'h0000_0003;
        end else begin
          check_eq("b2b_op2", 64'(bus.oData), 64'h30);
          last = 32'h0000_0030;
        end
      end else begin
        check_eq("b2b_stable", 64'(bus.oData), 64'(last));
      end
      prev_ready = bus.oReady;
    end
    check_eq("b2b_spacing", 64'(acc2 - acc1), 64'd6);
    check_eq("b2b_dones", 64'(dones), 64'd2);
    check_eq("b2b_ready", 64'(bus.oReady), 64'd1);

    // Reset asserted after two RUN cycles aborts the operation.
    bus.iStart  = 1'b1;
    bus.iData_a = 32'hFFFF_FFFF;
    bus.iData_b = 32'h0000_0001;
    bus.iC      = 1'b0;
    tick();
    bus.iStart = 1'b0;
    tick();
    tick();
    check_eq("mid_busy", 64'(bus.oBusy), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_ready", 64'(bus.oReady), 64'd1);
    check_eq("abort_busy", 64'(bus.oBusy), 64'd0);
    check_eq("abort_done", 64'(bus.oDone), 64'd0);
    check_eq("abort_data", 64'(bus.oData), 64'd0);
    check_eq("abort_carry", 64'(bus.oData_C), 64'd0);
    tick();
    rst = 1'b0;
    late_dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.oDone) late_dones++;
    end
    check_eq("abort_no_done", 64'(late_dones), 64'd0);
    check_eq("abort_data_held", 64'(bus.oData), 64'd0);

    run_op("fresh", 32'h1111_1111, 32'h2222_2222, 1'b1, 32'h3333_3334, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
